// File: rtl/pc_fetch_ctrl.sv
// Fetch PC owner and instruction-memory requester with a single outstanding request.
// Redirects from EX retarget fetch and discard any response that is still in flight.
module pc_fetch_ctrl #(
    parameter int PC_W   = 9,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              stall,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [PC_W-1:0]   if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              flush
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_WAIT  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]     inflight_pc_q, inflight_pc_d;
    logic                kill_q, kill_d;
    logic                if_valid_q, if_valid_d;
    logic [PC_W-1:0]     if_pc_q, if_pc_d;
    logic [INST_W-1:0]   if_inst_q, if_inst_d;

    logic                slot_free;
    logic                fire;
    logic [PC_W-1:0]     redirect_target;
    logic                unused_redirect_bits;

    // Only the word-aligned low bits of the target address the instruction memory.
    assign redirect_target      = {redirect_pc[PC_W-1:2], 2'b00};
    assign unused_redirect_bits = ^{redirect_pc[31:PC_W], redirect_pc[1:0]};
    assign fire                 = imem_req && imem_gnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= '0;
            inflight_pc_q <= '0;
            kill_q        <= 1'b0;
            if_valid_q    <= 1'b0;
            if_pc_q       <= '0;
            if_inst_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            kill_q        <= kill_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_inst_q     <= if_inst_d;
        end
    end

    // NOTE: every signal gets a hold default first, so no path through this block infers a latch.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        kill_d        = kill_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_inst_d     = if_inst_q;

        if (if_valid_q && !stall) begin
            if_valid_d = 1'b0;
        end

        case (state_q)
            S_FETCH: begin
                if (fire) begin
                    inflight_pc_d = fetch_pc_q;
                    fetch_pc_d    = fetch_pc_q + PC_W'(4);
                    kill_d        = redirect_valid;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                    kill_d  = 1'b0;
                    if (!kill_q && !redirect_valid) begin
                        if_inst_d  = imem_rdata;
                        if_pc_d    = inflight_pc_q;
                        if_valid_d = 1'b1;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // The target overrides any increment made by a grant in the same cycle.
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            if_valid_d = 1'b0;
        end
    end

    always_comb begin
        slot_free = !if_valid_q || !stall;
        imem_req  = !reset && (state_q == S_FETCH) && slot_free;
        imem_addr = fetch_pc_q;
        flush     = redirect_valid;
        if_valid  = if_valid_q;
        if_pc     = if_pc_q;
        if_inst   = if_inst_q;
    end

endmodule
